// File: rtl/zombie_round_sched_pkg.sv
// Shared types and constants for the punch-zombie round scheduler.
//   state_t      : round controller states
//   NUM_LANES    : number of zombie lanes / punch buttons
//   DEF_*        : default timing and game constants
//   lane_onehot  : lane index to one-hot lane mask
//   lives_thermo : lives count to thermometer LED pattern
package zombie_round_sched_pkg;

    localparam int NUM_LANES         = 3;
    localparam int DEF_UP_TICKS      = 48;
    localparam int DEF_UP_MIN        = 12;
    localparam int DEF_UP_STEP       = 4;
    localparam int DEF_SPEEDUP_EVERY = 4;
    localparam int DEF_GAP_TICKS     = 8;
    localparam int DEF_LIVES         = 3;
    localparam int DEF_SCORE_W       = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        SAMPLE = 3'd2,
        UP     = 3'd3,
        GAP    = 3'd4,
        OVER   = 3'd5
    } state_t;

    // Index 3 has no lane and maps to an all-zero mask.
    function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [1:0] idx);
        logic [NUM_LANES-1:0] mask;
        for (int i = 0; i < NUM_LANES; i++) begin
            mask[i] = (idx == 2'(i));
        end
        return mask;
    endfunction

    function automatic logic [2:0] lives_thermo(input logic [2:0] n);
        logic [2:0] t;
        for (int k = 0; k < 3; k++) begin
            t[k] = (n > 3'(k));
        end
        return t;
    endfunction

endpackage

// File: rtl/zombie_round_sched_if.sv
// Game-side bundle between the round scheduler and its surroundings.
//   master : drives tick/start/btn/rand_num, observes round status
//   slave  : the scheduler; consumes inputs, drives status and strobes
// Signals: tick (game-time enable), start (start/restart pulse), btn (punch
// buttons, level), rand_num (LFSR value), need_random (random request pulse),
// zombie_up (one-hot raised lane), shift (redraw strobe), ready/gaming/gameover
// (screen mode), score, lives, led (lives thermometer).
interface zombie_round_sched_if #(
    parameter int SCORE_W = 8
) ();
    import zombie_round_sched_pkg::*;

    logic                 tick;
    logic                 start;
    logic [NUM_LANES-1:0] btn;
    logic [1:0]           rand_num;
    logic                 need_random;
    logic [NUM_LANES-1:0] zombie_up;
    logic                 shift;
    logic                 ready;
    logic                 gaming;
    logic                 gameover;
    logic [SCORE_W-1:0]   score;
    logic [2:0]           lives;
    logic [2:0]           led;

    modport master (
        output tick, start, btn, rand_num,
        input  need_random, zombie_up, shift, ready, gaming, gameover,
               score, lives, led
    );

    modport slave (
        input  tick, start, btn, rand_num,
        output need_random, zombie_up, shift, ready, gaming, gameover,
               score, lives, led
    );

endinterface

// File: rtl/zombie_round_sched_hit_judge.sv
// Punch judge: detects rising edges on the buttons and classifies them
// against the currently raised zombie lane.
//   clk, rst  : clock, synchronous active-high reset
//   btn       : debounced buttons (level)
//   zombie_up : one-hot raised lane, or 0
//   hit       : registered, a rise occurred on the raised lane
//   wrong     : registered, a rise occurred on any other lane while a zombie is up
module zombie_round_sched_hit_judge
    import zombie_round_sched_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_LANES-1:0] btn,
    input  logic [NUM_LANES-1:0] zombie_up,
    output logic                 hit,
    output logic                 wrong
);

    logic [NUM_LANES-1:0] btn_prev_reg;
    logic [NUM_LANES-1:0] rise;
    logic                 hit_reg;
    logic                 wrong_reg;

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_rise
            assign rise[gi] = btn[gi] & ~btn_prev_reg[gi];
        end
    endgenerate

    // With no zombie raised there is nothing to get wrong; this also keeps a
    // press landing on the very edge a zombie appears from costing a life.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_prev_reg <= '0;
            hit_reg      <= 1'b0;
            wrong_reg    <= 1'b0;
        end else begin
            btn_prev_reg <= btn;
            hit_reg      <= |(rise & zombie_up);
            wrong_reg    <= (|zombie_up) && (|(rise & ~zombie_up));
        end
    end

    assign hit   = hit_reg;
    assign wrong = wrong_reg;

endmodule

// File: rtl/zombie_round_sched.sv
// Round controller for the 3-lane punch-zombie game. Requests a random lane,
// raises a zombie for up_len ticks, judges punches, tracks score and lives,
// speeds up as hits accumulate, and strobes shift whenever the picture changes.
//   clk, rst : shift clock, synchronous active-high reset
//   game     : slave side of zombie_round_sched_if (inputs tick/start/btn/
//              rand_num; registered outputs need_random/zombie_up/shift/
//              ready/gaming/gameover/score/lives/led)
module zombie_round_sched
    import zombie_round_sched_pkg::*;
#(
    parameter int UP_TICKS      = DEF_UP_TICKS,
    parameter int UP_MIN        = DEF_UP_MIN,
    parameter int UP_STEP       = DEF_UP_STEP,
    parameter int SPEEDUP_EVERY = DEF_SPEEDUP_EVERY,
    parameter int GAP_TICKS     = DEF_GAP_TICKS,
    parameter int LIVES         = DEF_LIVES,
    parameter int SCORE_W       = DEF_SCORE_W
) (
    input  logic                clk,
    input  logic                rst,
    zombie_round_sched_if.slave game
);

    localparam int CNT_W = $clog2(UP_TICKS + UP_MIN + UP_STEP + GAP_TICKS + 1);
    localparam int HIT_W = $clog2(SPEEDUP_EVERY + 1);

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;        // up-time or gap tick counter
    logic [CNT_W-1:0]     up_len_reg, up_len_next;
    logic [HIT_W-1:0]     hit_cnt_reg, hit_cnt_next;
    logic [SCORE_W-1:0]   score_reg, score_next;
    logic [2:0]           lives_reg, lives_next;
    logic [NUM_LANES-1:0] zombie_reg, zombie_next;
    logic                 shift_reg, shift_next;
    logic                 need_random_reg;
    logic                 ready_reg;
    logic                 gaming_reg;
    logic                 gameover_reg;
    logic [2:0]           led_reg;

    logic hit;
    logic wrong;
    logic timeout;

    zombie_round_sched_hit_judge u_judge (
        .clk       (clk),
        .rst       (rst),
        .btn       (game.btn),
        .zombie_up (zombie_reg),
        .hit       (hit),
        .wrong     (wrong)
    );

    assign timeout = game.tick && (cnt_reg == up_len_reg - 1'b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            up_len_reg      <= CNT_W'(UP_TICKS);
            hit_cnt_reg     <= '0;
            score_reg       <= '0;
            lives_reg       <= 3'(LIVES);
            zombie_reg      <= '0;
            shift_reg       <= 1'b0;
            need_random_reg <= 1'b0;
            ready_reg       <= 1'b1;
            gaming_reg      <= 1'b0;
            gameover_reg    <= 1'b0;
            led_reg         <= lives_thermo(3'(LIVES));
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            up_len_reg      <= up_len_next;
            hit_cnt_reg     <= hit_cnt_next;
            score_reg       <= score_next;
            lives_reg       <= lives_next;
            zombie_reg      <= zombie_next;
            shift_reg       <= shift_next;
            // Mode outputs follow the next state so they change on the same
            // edge as the state itself.
            need_random_reg <= (state_next == REQ);
            ready_reg       <= (state_next == IDLE);
            gameover_reg    <= (state_next == OVER);
            gaming_reg      <= (state_next != IDLE) && (state_next != OVER);
            led_reg         <= lives_thermo(lives_next);
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        up_len_next  = up_len_reg;
        hit_cnt_next = hit_cnt_reg;
        score_next   = score_reg;
        lives_next   = lives_reg;
        zombie_next  = zombie_reg;
        shift_next   = 1'b0;

        case (state_reg)
            IDLE, OVER: begin
                // IDLE keeps the game re-initialised; OVER holds its final
                // score until a restart clears it on the departing edge.
                if (state_reg == IDLE || game.start) begin
                    score_next   = '0;
                    lives_next   = 3'(LIVES);
                    up_len_next  = CNT_W'(UP_TICKS);
                    hit_cnt_next = '0;
                    cnt_next     = '0;
                end
                if (game.start) begin
                    state_next = REQ;
                end
            end

            REQ: begin
                state_next = SAMPLE;
            end

            SAMPLE: begin
                if (game.rand_num != 2'd3) begin
                    zombie_next = lane_onehot(game.rand_num);
                    shift_next  = 1'b1;
                    cnt_next    = '0;
                    state_next  = UP;
                end else begin
                    state_next = REQ;
                end
            end

            UP: begin
                if (wrong || hit || timeout) begin
                    zombie_next = '0;
                    shift_next  = 1'b1;
                    cnt_next    = '0;
                    if (!wrong && hit) begin
                        if (score_reg != '1) begin
                            score_next = score_reg + 1'b1;
                        end
                        if (hit_cnt_reg == HIT_W'(SPEEDUP_EVERY - 1)) begin
                            hit_cnt_next = '0;
                            if (up_len_reg >= CNT_W'(UP_MIN + UP_STEP)) begin
                                up_len_next = up_len_reg - CNT_W'(UP_STEP);
                            end else begin
                                up_len_next = CNT_W'(UP_MIN);
                            end
                        end else begin
                            hit_cnt_next = hit_cnt_reg + 1'b1;
                        end
                        state_next = GAP;
                    end else begin
                        lives_next = lives_reg - 1'b1;
                        state_next = (lives_reg == 3'd1) ? OVER : GAP;
                    end
                end else if (game.tick) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            GAP: begin
                if (game.tick) begin
                    if (cnt_reg == CNT_W'(GAP_TICKS - 1)) begin
                        cnt_next   = '0;
                        state_next = REQ;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign game.need_random = need_random_reg;
    assign game.zombie_up   = zombie_reg;
    assign game.shift       = shift_reg;
    assign game.ready       = ready_reg;
    assign game.gaming      = gaming_reg;
    assign game.gameover    = gameover_reg;
    assign game.score       = score_reg;
    assign game.lives       = lives_reg;
    assign game.led         = led_reg;

endmodule

// File: tb/tb_zombie_round_sched.sv
// Directed bench for zombie_round_sched: a cycle-by-cycle vector table for the
// first game (start, hit, held button, timeouts down to game over) followed by
// hand-written sequences for retry, wrong-lane punch, mid-game reset and
// speed-up down to the up-time floor.
module tb_zombie_round_sched;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    zombie_round_sched_if #(.SCORE_W(8)) game ();

    zombie_round_sched #(
        .UP_TICKS      (4),
        .UP_MIN        (2),
        .UP_STEP       (1),
        .SPEEDUP_EVERY (2),
        .GAP_TICKS     (2),
        .LIVES         (3),
        .SCORE_W       (8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .game (game)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic [2:0] b;
        logic [1:0] r;
        logic       nr;
        logic [2:0] zu;
        logic       sh;
        logic       rdy;
        logic       gm;
        logic       go;
        logic [7:0] sc;
        logic [2:0] lv;
    } vec_t;

    localparam int NVEC = 30;
    vec_t vecs[NVEC];

    function automatic vec_t mk(input int st, input int b, input int r, input int nr,
                                input int zu, input int sh, input int rdy, input int gm,
                                input int go, input int sc, input int lv);
        vec_t v;
        v.st = 1'(st);  v.b = 3'(b);   v.r = 2'(r);
        v.nr = 1'(nr);  v.zu = 3'(zu); v.sh = 1'(sh);
        v.rdy = 1'(rdy); v.gm = 1'(gm); v.go = 1'(go);
        v.sc = 8'(sc);  v.lv = 3'(lv);
        return v;
    endfunction

    function automatic logic [2:0] led_of(input logic [2:0] n);
        case (n)
            3'd0:    return 3'b000;
            3'd1:    return 3'b001;
            3'd2:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end else begin
            $display("ok   %s = %0d", name, got);
        end
    endtask

    task automatic cyc(input logic s, input logic [2:0] b, input logic [1:0] r);
        @(negedge clk);
        game.start    = s;
        game.btn      = b;
        game.rand_num = r;
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a random request, then answer it with the given lane.
    task automatic to_up(input int lane);
        int n;
        n = 0;
        while (!game.need_random && n < 20) begin
            cyc(1'b0, 3'b000, 2'd0);
            n++;
        end
        if (!game.need_random) begin
            total++;
            bad++;
            $display("FAIL need_random_wait got=timeout exp=pulse");
        end
        cyc(1'b0, 3'b000, 2'd0);
        cyc(1'b0, 3'b000, 2'(lane));
        chk($sformatf("zombie_up_lane%0d", lane), int'(game.zombie_up), 1 << lane);
    endtask

    task automatic hit(input int lane, input int exp_score);
        cyc(1'b0, 3'(1 << lane), 2'd0);
        cyc(1'b0, 3'b000, 2'd0);
        chk("hit_score", int'(game.score), exp_score);
        chk("hit_clear", int'(game.zombie_up), 0);
    endtask

    // Count post-edge samples with the zombie raised, then check lives.
    task automatic measure(input int exp_len, input int exp_lives);
        int n;
        n = 1;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 3'b000, 2'd0);
            if (game.zombie_up != 3'b000) n++;
            else break;
        end
        chk("up_time", n, exp_len);
        chk("timeout_lives", int'(game.lives), exp_lives);
    endtask

    initial begin
        logic [21:0] got;
        logic [21:0] exp;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        game.tick     = 1'b1;
        game.start    = 1'b0;
        game.btn      = 3'b000;
        game.rand_num = 2'd0;

        //              st b r  nr zu  sh rdy gm go sc lv
        vecs[0]  = mk(1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 3);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3);
        vecs[2]  = mk(0, 0, 1, 0, 2, 1, 0, 1, 0, 0, 3);
        vecs[3]  = mk(0, 2, 0, 0, 2, 0, 0, 1, 0, 0, 3);
        vecs[4]  = mk(0, 2, 0, 0, 0, 1, 0, 1, 0, 1, 3);
        vecs[5]  = mk(0, 2, 0, 0, 0, 0, 0, 1, 0, 1, 3);
        vecs[6]  = mk(0, 2, 0, 1, 0, 0, 0, 1, 0, 1, 3);
        vecs[7]  = mk(0, 2, 0, 0, 0, 0, 0, 1, 0, 1, 3);
        vecs[8]  = mk(0, 2, 1, 0, 2, 1, 0, 1, 0, 1, 3);
        vecs[9]  = mk(0, 2, 0, 0, 2, 0, 0, 1, 0, 1, 3);
        vecs[10] = mk(0, 2, 0, 0, 2, 0, 0, 1, 0, 1, 3);
        vecs[11] = mk(0, 2, 0, 0, 2, 0, 0, 1, 0, 1, 3);
        vecs[12] = mk(0, 2, 0, 0, 0, 1, 0, 1, 0, 1, 2);
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2);
        vecs[14] = mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 2);
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2);
        vecs[16] = mk(0, 0, 0, 0, 1, 1, 0, 1, 0, 1, 2);
        vecs[17] = mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 2);
        vecs[18] = mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 2);
        vecs[19] = mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 2);
        vecs[20] = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 1);
        vecs[21] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
        vecs[22] = mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 1);
        vecs[23] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
        vecs[24] = mk(0, 0, 0, 0, 1, 1, 0, 1, 0, 1, 1);
        vecs[25] = mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 1);
        vecs[26] = mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 1);
        vecs[27] = mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 1);
        vecs[28] = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0);
        vecs[29] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);

        // Reset state
        cyc(1'b0, 3'b000, 2'd0);
        cyc(1'b0, 3'b000, 2'd0);
        chk("rst_ready", int'(game.ready), 1);
        chk("rst_gaming", int'(game.gaming), 0);
        chk("rst_gameover", int'(game.gameover), 0);
        chk("rst_outs", int'({game.need_random, game.shift, game.zombie_up}), 0);
        chk("rst_score", int'(game.score), 0);
        chk("rst_lives", int'(game.lives), 3);
        chk("rst_led", int'(game.led), 7);
        @(negedge clk);
        rst = 1'b0;

        // First game, cycle by cycle
        for (int i = 0; i < NVEC; i++) begin
            cyc(vecs[i].st, vecs[i].b, vecs[i].r);
            got = {game.need_random, game.zombie_up, game.shift, game.ready, game.gaming,
                   game.gameover, game.score, game.lives, game.led};
            exp = {vecs[i].nr, vecs[i].zu, vecs[i].sh, vecs[i].rdy, vecs[i].gm,
                   vecs[i].go, vecs[i].sc, vecs[i].lv, led_of(vecs[i].lv)};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL vec%0d got=%h exp=%h", i, got, exp);
            end else begin
                $display("ok   vec%0d = %h", i, got);
            end
        end

        // Restart from OVER
        cyc(1'b1, 3'b000, 2'd0);
        chk("restart_nr", int'(game.need_random), 1);
        chk("restart_score", int'(game.score), 0);
        chk("restart_lives", int'(game.lives), 3);
        chk("restart_mode", int'({game.ready, game.gaming, game.gameover}), 3'b010);

        // rand_num=3 retries without a redraw
        cyc(1'b0, 3'b000, 2'd0);
        cyc(1'b0, 3'b000, 2'd3);
        chk("retry_nr", int'(game.need_random), 1);
        chk("retry_shift", int'(game.shift), 0);
        chk("retry_zombie", int'(game.zombie_up), 0);
        cyc(1'b0, 3'b000, 2'd0);
        cyc(1'b0, 3'b000, 2'd2);
        chk("retry_lane2", int'(game.zombie_up), 4);
        chk("retry_lane2_shift", int'(game.shift), 1);

        // Correct and wrong lane rising together is a miss
        cyc(1'b0, 3'b101, 2'd0);
        cyc(1'b0, 3'b101, 2'd0);
        chk("both_lives", int'(game.lives), 2);
        chk("both_score", int'(game.score), 0);
        chk("both_zombie", int'(game.zombie_up), 0);
        chk("both_shift", int'(game.shift), 1);
        cyc(1'b0, 3'b000, 2'd0);
        to_up(0);

        // Reset during UP
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_ready", int'(game.ready), 1);
        chk("midrst_zombie", int'(game.zombie_up), 0);
        chk("midrst_lives", int'(game.lives), 3);
        chk("midrst_nr", int'(game.need_random), 0);
        @(negedge clk);
        rst = 1'b0;

        // Speed-up: up_len 4 -> 3 -> 2 -> stays 2
        cyc(1'b1, 3'b000, 2'd0);
        to_up(0); hit(0, 1);
        to_up(1); hit(1, 2);
        to_up(2); measure(3, 2);
        to_up(0); hit(0, 3);
        to_up(1); hit(1, 4);
        to_up(2); hit(2, 5);
        to_up(0); hit(0, 6);
        to_up(1); measure(2, 1);
        to_up(2); measure(2, 0);
        chk("over_gameover", int'(game.gameover), 1);
        chk("over_gaming", int'(game.gaming), 0);
        cyc(1'b0, 3'b001, 2'd0);
        cyc(1'b0, 3'b000, 2'd0);
        chk("over_score_frozen", int'(game.score), 6);
        chk("over_led", int'(game.led), 0);
        cyc(1'b1, 3'b000, 2'd0);
        chk("over_restart_score", int'(game.score), 0);
        chk("over_restart_lives", int'(game.lives), 3);
        chk("over_restart_nr", int'(game.need_random), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/zombie_round_sched.md
Name: zombie_round_sched

Overview:
- Game-round controller for the 3-lane punch-zombie LED game.
- Picks a lane for each zombie by requesting a value from the LFSR random source, then raises that zombie for a bounded time.
- Judges button punches, keeps score and lives, and shortens the up-time as the score grows.
- Drives ready/gaming/gameover and the redraw strobe into the picture-shift/data-driver datapath. Runs on the shift clock domain.

Parameters:
- UP_TICKS, 48: initial zombie up-time, in game ticks.
- UP_MIN, 12: floor for the up-time.
- UP_STEP, 4: amount the up-time is reduced at each speed-up.
- SPEEDUP_EVERY, 4: number of hits between speed-ups.
- GAP_TICKS, 8: blank time between zombies, in ticks.
- LIVES, 3: starting lives; must be 1..7.
- SCORE_W, 8: score width.

Ports:
- clk in 1: shift clock.
- rst in 1: reset.
- tick in 1: one-cycle game-time enable.
- start in 1: start/restart pulse.
- btn in 3: debounced punch buttons, level; bit i is lane i.
- rand_num in 2: LFSR output.
- need_random out 1: one-cycle random request pulse.
- zombie_up out 3: one-hot lane of the raised zombie, or 0.
- shift out 1: one-cycle redraw strobe.
- ready out 1: idle/title screen.
- gaming out 1: game in progress.
- gameover out 1: game over.
- score out SCORE_W: hit count.
- lives out 3: lives remaining.
- led out 3: lives shown as a thermometer.

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-high.
- Reset values:
  - state=IDLE, ready=1, gaming=0, gameover=0.
  - zombie_up=0, need_random=0, shift=0.
  - score=0, lives=LIVES, up_len=UP_TICKS.
  - All counters 0. btn edge registers = 0.
- Reset mid-operation aborts immediately to IDLE with these values; any in-flight random request is discarded.
- Button edges: btn_prev is registered each cycle; rise = btn & ~btn_prev. Only rises are judged, so a held button never scores twice.
- States:
  - IDLE: ready=1. start -> REQ. Also: score=0, lives=LIVES, up_len=UP_TICKS, hit_cnt=0.
  - REQ: need_random=1 for exactly one cycle, then -> SAMPLE.
  - SAMPLE: rand_num is captured on the cycle after the request. Value 0..2: zombie_up = 1<<rand_num, shift=1, tick_cnt=0 -> UP. Value 3: -> REQ (retry, no shift).
  - UP: gaming=1. Judgement, in priority order:
    1. Any rise on a lane other than the raised one -> miss.
    2. Else a rise on the raised lane -> hit.
    3. Else on tick: tick_cnt+1; when tick_cnt reaches up_len-1 -> miss (timeout).
    - Hit: score+1, saturating at 2^SCORE_W-1; hit_cnt+1. When hit_cnt wraps at SPEEDUP_EVERY, up_len = max(up_len-UP_STEP, UP_MIN).
    - Hit or miss: zombie_up=0, shift=1, tick_cnt=0.
    - Miss: lives-1. If lives becomes 0 -> OVER, else -> GAP.
    - A simultaneous correct and wrong rise counts as a miss.
    - A rise on the same cycle as the timeout tick counts as a punch, not a timeout.
  - GAP: gaming=1, zombie_up=0, buttons ignored. Count GAP_TICKS ticks, then -> REQ.
  - OVER: gameover=1, gaming=0. score and lives are frozen. start -> IDLE-equivalent re-init then REQ in the same transition; score cleared on that edge.
- start is ignored in REQ, SAMPLE, UP and GAP.
- ready, gaming and gameover are mutually exclusive, one-hot over IDLE / play / OVER. REQ and SAMPLE count as play (gaming=1).
- led = thermometer(lives): bit k = (lives > k). All outputs are registered; state change is visible the cycle after the cause.
- Latency figures:
  - start to need_random: 1 cycle.
  - need_random to zombie_up valid: 2 cycles.
  - Punch rise (btn sampled) to shift/zombie_up=0: 2 cycles (edge register plus state register).

Decomposition:
- zombie_pkg holds:
  - state enum (IDLE, REQ, SAMPLE, UP, GAP, OVER);
  - lane width constant NUM_LANES=3;
  - default tick constants.
- One sub-module is natural: zombie_hit_judge (combinational plus the btn_prev register). Inputs are btn and zombie_up; outputs are hit, wrong. This lets the judge be unit-tested alone.

Test Plan:
- Bench parameters for all scenarios: UP_TICKS=4, GAP_TICKS=2, LIVES=3, SPEEDUP_EVERY=2, UP_STEP=1, UP_MIN=2. tick is held high throughout.
1. Reset, then start; feed rand_num=1 -> need_random pulses 1 cycle; zombie_up=3'b010 two cycles later; shift=1 for one cycle; ready=0, gaming=1.
2. Lane 1 up; raise btn[1] -> score=1, zombie_up=0, shift pulse; after 2 ticks need_random again. Holding btn[1] through the next round gives no second hit.
3. Lane 0 up; no press for 4 ticks -> lives 3->2, led=3'b011. Repeat twice more -> lives=0, gameover=1, gaming=0, score frozen.
4. rand_num=3 on sample -> a second need_random 1 cycle later and no shift. Then rand_num=2 -> zombie_up=3'b100.
5. Lane 2 up; btn=3'b101 rises together -> miss (lives-1), score unchanged. Assert rst during UP -> next cycle ready=1, zombie_up=0, lives=3, score=0.
6. Four consecutive hits -> up_len goes 4->3->2, then stays 2 at the floor. Confirm a timeout occurs after 2 ticks. In OVER, start -> score=0, lives=3, need_random pulse.
